mesi_bus_arbiter: RTL and testbench

//   Snooping-bus controller for N MESI cache FSMs sharing one bus. Arbitrates read/write misses

---
 rtl/mesi_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 39 +++
 rtl/mesi_bus_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_mesi_bus_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mesi_pkg.sv
// mesi_pkg
//   Shared types for the MESI snooping-bus arbiter.
//   - mesi_e      : two-bit MESI line-state encoding as seen on line_state
//                   (M=00, E=01, S=11, I=10).
//   - arb_state_e : bus-sequencer FSM states.
package mesi_pkg;

  typedef enum logic [1:0] {
    MESI_M = 2'b00,
    MESI_E = 2'b01,
    MESI_S = 2'b11,
    MESI_I = 2'b10
  } mesi_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_SNOOP,
    ST_FLUSH,
    ST_DONE
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin pick. Scans req starting at ptr and wrapping
//   N-1 -> 0; the first set bit wins.
// Ports
//   req   in  N   request vector
//   ptr   in  IW  index of the highest-priority requester this round
//   grant out N   one-hot winner (all zero when req is zero)
//   idx   out IW  binary index of the winner (0 when req is zero)
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] cand;
  logic          found;

  // NOTE: every signal written here gets a default first so no path through
  // the loop leaves it unassigned, which would infer a latch.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      cand = IW'((int'(ptr) + i) % N);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/mesi_bus_arbiter.sv
// mesi_bus_arbiter
//   Snooping-bus controller for N_CACHE MESI cache controllers sharing one
//   bus. Picks one requester round-robin, then sequences the transaction:
//   GRANT -> SNOOP (BR/BW broadcast to all other caches, shared collect) ->
//   DONE. The round-robin pointer moves past the owner on every DONE.
//
//   Optional feature macro: MESI_WRITEBACK_EN
//     When defined, a snooped cache holding the line in M (lowest index wins)
//     is asked to write back via flush[k]; the sequencer waits in FLUSH until
//     flush_ack, then finishes with DONE. When undefined, flush is tied 0 and
//     flush_ack is ignored.
//
// Ports
//   clk         in   1          clock
//   rst         in   1          asynchronous active-low reset
//   req         in   N_CACHE    per-cache bus request, held until own done
//   req_wr      in   N_CACHE    per-cache op: 1 = write/invalidate, 0 = read
//   line_state  in   2*N_CACHE  MESI state of the addressed line, cache k at [2k+1:2k]
//   flush_ack   in   1          memory accepted the write-back
//   gnt         out  N_CACHE    one-hot grant to the current owner (GRANT..DONE)
//   bus_br      out  N_CACHE    snoop-read pulse to every non-owner
//   bus_bw      out  N_CACHE    snoop-write/invalidate pulse to every non-owner
//   shared      out  N_CACHE    shared result to owner, valid with done
//   done        out  N_CACHE    one-cycle completion pulse to owner
//   flush       out  N_CACHE    write-back request to the snooped cache in M
//   busy        out  1          high whenever the sequencer is not idle
module mesi_bus_arbiter
  import mesi_pkg::*;
#(
  parameter int N_CACHE = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CACHE-1:0]     req,
  input  logic [N_CACHE-1:0]     req_wr,
  input  logic [2*N_CACHE-1:0]   line_state,
  input  logic                   flush_ack,
  output logic [N_CACHE-1:0]     gnt,
  output logic [N_CACHE-1:0]     bus_br,
  output logic [N_CACHE-1:0]     bus_bw,
  output logic [N_CACHE-1:0]     shared,
  output logic [N_CACHE-1:0]     done,
  output logic [N_CACHE-1:0]     flush,
  output logic                   busy
);

  localparam int IW = $clog2(N_CACHE);

  arb_state_e        state_q, state_d;
  logic [IW-1:0]     owner_q;
  logic              op_q;        // 1 = write transaction
  logic              shared_q;
  logic [IW-1:0]     ptr_q;

  logic [N_CACHE-1:0] pick_oh;
  logic [IW-1:0]      pick_idx;
  logic               pick_valid;
  logic               pick_op;
  logic               snoop_shared;
  logic [N_CACHE-1:0] owner_oh;

  rr_arbiter #(
    .N  (N_CACHE),
    .IW (IW)
  ) u_rr (
    .req   (req),
    .ptr   (ptr_q),
    .grant (pick_oh),
    .idx   (pick_idx)
  );

  assign pick_valid = |pick_oh;
  assign pick_op    = |(req_wr & pick_oh);
  assign owner_oh   = N_CACHE'(1) << owner_q;

  // Any other cache holding the line (E, S or M) makes the owner's copy shared.
  always_comb begin
    snoop_shared = 1'b0;
    for (int k = 0; k < N_CACHE; k++) begin
      if (IW'(k) != owner_q && line_state[2*k +: 2] != MESI_I) begin
        snoop_shared = 1'b1;
      end
    end
  end

`ifdef MESI_WRITEBACK_EN
  logic          m_found;
  logic [IW-1:0] m_idx;
  logic [IW-1:0] flush_idx_q;

  // Lowest-index non-owner in M supplies the write-back.
  always_comb begin
    m_found = 1'b0;
    m_idx   = '0;
    for (int k = 0; k < N_CACHE; k++) begin
      if (!m_found && IW'(k) != owner_q && line_state[2*k +: 2] == MESI_M) begin
        m_found = 1'b1;
        m_idx   = IW'(k);
      end
    end
  end
`else
  logic flush_ack_unused;
  assign flush_ack_unused = flush_ack;
`endif

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (pick_valid) state_d = ST_GRANT;
      ST_GRANT: state_d = ST_SNOOP;
`ifdef MESI_WRITEBACK_EN
      ST_SNOOP: state_d = m_found ? ST_FLUSH : ST_DONE;
      ST_FLUSH: if (flush_ack) state_d = ST_DONE;
`else
      ST_SNOOP: state_d = ST_DONE;
`endif
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State register and transaction latches. Reset is asynchronous so a
  // transaction in flight is abandoned immediately.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= '0;
      op_q        <= 1'b0;
      shared_q    <= 1'b0;
      ptr_q       <= '0;
`ifdef MESI_WRITEBACK_EN
      flush_idx_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && pick_valid) begin
        owner_q <= pick_idx;
        op_q    <= pick_op;
      end
      if (state_q == ST_SNOOP) begin
        shared_q    <= snoop_shared;
`ifdef MESI_WRITEBACK_EN
        flush_idx_q <= m_idx;
`endif
      end
      if (state_q == ST_DONE) begin
        ptr_q <= (owner_q == IW'(N_CACHE - 1)) ? '0 : owner_q + IW'(1);
      end
    end
  end

  // Output decode: purely a function of state and latches, so outputs drop
  // to zero as soon as reset is asserted.
  always_comb begin
    gnt    = '0;
    bus_br = '0;
    bus_bw = '0;
    shared = '0;
    done   = '0;
    flush  = '0;
    busy   = (state_q != ST_IDLE);
    if (state_q != ST_IDLE) gnt = owner_oh;
    case (state_q)
      ST_SNOOP: begin
        if (op_q) bus_bw = ~owner_oh;
        else      bus_br = ~owner_oh;
      end
`ifdef MESI_WRITEBACK_EN
      ST_FLUSH: flush = N_CACHE'(1) << flush_idx_q;
`endif
      ST_DONE: begin
        done = owner_oh;
        if (shared_q) shared = owner_oh;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mesi_bus_arbiter.sv
// tb_mesi_bus_arbiter
//   Directed bench for mesi_bus_arbiter (N_CACHE=4). A transaction-level
//   model (owner, age within the transaction, round-robin pointer) predicts
//   every output each cycle; directed steps add hand-computed literal checks.
module tb_mesi_bus_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req, req_wr;
  logic [2*N-1:0] line_state;
  logic           flush_ack;
  logic [N-1:0]   gnt, bus_br, bus_bw, shared, done, flush;
  logic           busy;

  int n_vec = 0;
  int n_err = 0;

  mesi_bus_arbiter #(.N_CACHE(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_wr     (req_wr),
    .line_state (line_state),
    .flush_ack  (flush_ack),
    .gnt        (gnt),
    .bus_br     (bus_br),
    .bus_bw     (bus_bw),
    .shared     (shared),
    .done       (done),
    .flush      (flush),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++) if (r[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  function automatic bit others_hold(input logic [2*N-1:0] ls, input int own);
    for (int k = 0; k < N; k++) if (k != own && ls[2*k +: 2] != 2'b10) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int lowest_m(input logic [2*N-1:0] ls, input int own);
    for (int k = 0; k < N; k++) if (k != own && ls[2*k +: 2] == 2'b00) return k;
    return -1;
  endfunction

  bit m_active, m_op, m_shared, m_flushing;
  int m_age, m_owner, m_ptr, m_flush_idx;

  // m_age: 1 = grant cycle, 2 = snoop cycle, 3 = done cycle.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_active <= 1'b0; m_op <= 1'b0; m_shared <= 1'b0; m_flushing <= 1'b0;
      m_age <= 0; m_owner <= 0; m_ptr <= 0; m_flush_idx <= 0;
    end else if (!m_active) begin
      if (rr_pick(req, m_ptr) >= 0) begin
        m_active <= 1'b1;
        m_age    <= 1;
        m_owner  <= rr_pick(req, m_ptr);
        m_op     <= req_wr[rr_pick(req, m_ptr)];
      end
    end else if (m_flushing) begin
      if (flush_ack) begin
        m_flushing <= 1'b0;
        m_age      <= 3;
      end
    end else if (m_age == 1) begin
      m_age <= 2;
    end else if (m_age == 2) begin
      m_shared <= others_hold(line_state, m_owner);
`ifdef MESI_WRITEBACK_EN
      if (lowest_m(line_state, m_owner) >= 0) begin
        m_flushing  <= 1'b1;
        m_flush_idx <= lowest_m(line_state, m_owner);
      end else begin
        m_age <= 3;
      end
`else
      m_age <= 3;
`endif
    end else begin
      m_active <= 1'b0;
      m_ptr    <= (m_owner + 1) % N;
    end
  end

  logic [N-1:0] e_gnt, e_br, e_bw, e_done, e_shared, e_flush;
  assign e_gnt    = m_active ? (N'(1) << m_owner) : '0;
  assign e_br     = (m_active && m_age == 2 && !m_flushing && !m_op) ? ~e_gnt : '0;
  assign e_bw     = (m_active && m_age == 2 && !m_flushing &&  m_op) ? ~e_gnt : '0;
  assign e_done   = (m_active && m_age == 3) ? e_gnt : '0;
  assign e_shared = (m_active && m_age == 3 && m_shared) ? e_gnt : '0;
  assign e_flush  = m_flushing ? (N'(1) << m_flush_idx) : '0;

  // Compare process: every output, every cycle, on the falling edge.
  always @(negedge clk) begin
    check("m_gnt",    32'(gnt),    32'(e_gnt));
    check("m_bus_br", 32'(bus_br), 32'(e_br));
    check("m_bus_bw", 32'(bus_bw), 32'(e_bw));
    check("m_done",   32'(done),   32'(e_done));
    check("m_shared", 32'(shared), 32'(e_shared));
    check("m_flush",  32'(flush),  32'(e_flush));
    check("m_busy",   32'(busy),   32'(m_active));
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic to_neg(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_done(output int idx);
    idx = -1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done !== '0) begin
        for (int b = 0; b < N; b++) if (done[b]) idx = b;
        return;
      end
    end
    n_vec++;
    n_err++;
    $display("FAIL done_timeout: no done within 12 cycles (t=%0t)", $time);
  endtask

  int order [4];
  int got;

  initial begin
    req = '0; req_wr = '0; line_state = 8'b10_10_10_10; flush_ack = 1'b0;
    rst = 1'b1;
    #2 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_gnt",  32'(gnt),  32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    @(posedge clk); #1 rst = 1'b1;

    // Fairness: all four request, each drops after its own done
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      wait_done(got);
      order[i] = got;
      if (got >= 0) req[got] = 1'b0;
    end
    req = '0;
    check("order0", 32'(order[0]), 32'd0);
    check("order1", 32'(order[1]), 32'd1);
    check("order2", 32'(order[2]), 32'd2);
    check("order3", 32'(order[3]), 32'd3);

    // Pointer wrapped to 0: cache0 beats cache3
    req = 4'b1001;
    to_neg(2);
    check("wrap_gnt", 32'(gnt), 32'h1);
    to_neg(2);
    check("wrap_done", 32'(done), 32'h1);
    req = '0;
    to_neg(1);

    // Single read, cache2 holds S
    step();
    line_state = 8'b10_11_10_10;
    req = 4'b0001; req_wr = 4'b0000;
    to_neg(1);
    check("rd_gnt", 32'(gnt), 32'h1);
    to_neg(1);
    check("rd_br", 32'(bus_br), 32'he);
    check("rd_bw", 32'(bus_bw), 32'h0);
    to_neg(1);
    check("rd_done",   32'(done),   32'h1);
    check("rd_shared", 32'(shared), 32'h1);
    req = '0;
    to_neg(1);
    check("rd_idle", 32'(busy), 32'h0);

    // Read with all other caches I; owner's own M must be ignored
    step();
    line_state = 8'b10_10_10_00;
    req = 4'b0001;
    to_neg(3);
    check("rdI_done",   32'(done),   32'h1);
    check("rdI_shared", 32'(shared), 32'h0);
    req = '0;
    to_neg(1);

    // Write from cache2
    step();
    line_state = 8'b10_10_10_10;
    req = 4'b0100; req_wr = 4'b0100;
    to_neg(2);
    check("wr_bw", 32'(bus_bw), 32'hb);
    check("wr_br", 32'(bus_br), 32'h0);
    to_neg(1);
    check("wr_done",  32'(done),   32'h4);
    check("wr_bw_1c", 32'(bus_bw), 32'h0);
    req = '0; req_wr = '0;
    to_neg(1);

    // Withdraw: cache1 drops its request while cache0 owns the bus
    step();
    req = 4'b0011;
    to_neg(1);
    check("wd_gnt", 32'(gnt), 32'h1);
    req[1] = 1'b0;
    to_neg(2);
    check("wd_done", 32'(done), 32'h1);
    req = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("wd_no_gnt1", 32'(gnt[1]), 32'h0);
    end
    check("wd_idle", 32'(busy), 32'h0);

    // Reset mid-SNOOP, then a fresh request from cache0
    step();
    req = 4'b0010;
    to_neg(2);
    check("rs_snoop", 32'(bus_br), 32'hd);
    #1 rst = 1'b0;
    req = 4'b0001;
    @(negedge clk);
    check("rs_gnt",  32'(gnt),    32'h0);
    check("rs_br",   32'(bus_br), 32'h0);
    check("rs_busy", 32'(busy),   32'h0);
    @(posedge clk); #1 rst = 1'b1;
    to_neg(1);
    check("rs_regnt", 32'(gnt), 32'h1);
    to_neg(2);
    check("rs_done", 32'(done), 32'h1);
    req = '0;
    to_neg(1);

    // cache3 holds M, cache0 reads
    step();
    line_state = 8'b00_10_10_10;
    req = 4'b0001;
    to_neg(2);
    check("wb_br", 32'(bus_br), 32'he);
`ifdef MESI_WRITEBACK_EN
    to_neg(1);
    check("wb_flush3", 32'(flush), 32'h8);
    check("wb_nodone", 32'(done),  32'h0);
    to_neg(1);
    check("wb_flush4", 32'(flush), 32'h8);
    step();
    flush_ack = 1'b1;
    @(negedge clk);
    check("wb_flush5", 32'(flush), 32'h8);
    step();
    flush_ack = 1'b0;
    @(negedge clk);
    check("wb_done",   32'(done),   32'h1);
    check("wb_shared", 32'(shared), 32'h1);
    check("wb_noflush", 32'(flush), 32'h0);
    req = '0;
`else
    to_neg(1);
    check("wb_done",    32'(done),   32'h1);
    check("wb_shared",  32'(shared), 32'h1);
    check("wb_noflush", 32'(flush),  32'h0);
    req = '0;
    step();
    step();
    flush_ack = 1'b1;
    @(negedge clk);
    check("wb_ack_ign", 32'(busy), 32'h0);
    step();
    flush_ack = 1'b0;
`endif
    line_state = 8'b10_10_10_10;
    to_neg(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
